// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the serial pattern detector.
package seq_det_pkg;

  localparam logic [2:0] DEF_PAT = 3'b101;

  // Width needed to hold a match length of 0..pat_w.
  function automatic int unsigned state_w(input int unsigned pat_w);
    return $clog2(pat_w + 1);
  endfunction

  // Pattern widths the detector supports.
  function automatic bit pat_w_ok(input int unsigned pat_w);
    return (pat_w >= 2) && (pat_w <= 16);
  endfunction

  // Counter widths the detector supports.
  function automatic bit cnt_w_ok(input int unsigned cnt_w);
    return (cnt_w >= 1) && (cnt_w <= 32);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with sticky saturation flag and synchronous clear.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         areset_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic         sat
);

  localparam logic [W-1:0] MAX = '1;

  // Clear wins over increment; the count stops at all-ones and latches sat.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      cnt <= '0;
      sat <= 1'b0;
    end else if (clr) begin
      cnt <= '0;
      sat <= 1'b0;
    end else if (inc && (cnt != MAX)) begin
      cnt <= cnt + W'(1);
      if (cnt == (MAX - W'(1))) sat <= 1'b1;
    end
  end

endmodule

// File: rtl/seq_pattern_detector.sv
// Configurable Moore detector for a serial bit stream with a saturating match counter.
module seq_pattern_detector
  import seq_det_pkg::*;
#(
  parameter int unsigned       PAT_W   = 3,
  parameter int unsigned       CNT_W   = 8,
  parameter logic [PAT_W-1:0]  RST_PAT = PAT_W'(DEF_PAT),
  parameter logic              RST_OVL = 1'b1
) (
  input  logic             clk,
  input  logic             areset_n,
  input  logic             in_valid,
  input  logic             in,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic             cfg_overlap,
  input  logic             cnt_clr,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat
);

  localparam int unsigned      SW     = state_w(PAT_W);
  localparam int unsigned      HW     = PAT_W - 1;
  localparam logic [SW-1:0]    S_FULL = SW'(PAT_W);
  localparam logic [PAT_W-1:0] ONES   = '1;

  if (!pat_w_ok(PAT_W)) begin : g_bad_pat_w
    $error("seq_pattern_detector: PAT_W must be within 2..16");
  end
  if (!cnt_w_ok(CNT_W)) begin : g_bad_cnt_w
    $error("seq_pattern_detector: CNT_W must be within 1..32");
  end

  logic [SW-1:0]    state_q, state_d, base;
  logic [HW-1:0]    hist_q, hist_d;
  logic [PAT_W-1:0] pat_q, win, pre, msk;
  logic             ovl_q;
  logic             match_q, match_d;
  logic             inc_c;

  // State register: match length, bit history, configuration and the match flag.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state_q <= '0;
      hist_q  <= '0;
      pat_q   <= RST_PAT;
      ovl_q   <= RST_OVL;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      match_q <= match_d;
      if (cfg_load) begin
        pat_q <= cfg_pattern;
        ovl_q <= cfg_overlap;
      end
    end
  end

  // Next state: longest pattern prefix that is a suffix of history plus the new bit.
  // Only the last `base` history bits are real (they equal the current prefix), so
  // candidate lengths are capped at base+1; this reproduces the KMP fallback.
  always_comb begin
    state_d = state_q;
    hist_d  = hist_q;
    win     = {hist_q, in};
    base    = state_q;
    pre     = '0;
    msk     = '0;
    if (!ovl_q && (state_q == S_FULL)) base = '0;
    if (cfg_load) begin
      state_d = '0;
      hist_d  = '0;
    end else if (in_valid) begin
      hist_d  = win[HW-1:0];
      state_d = '0;
      for (int unsigned k = 1; k <= PAT_W; k++) begin
        pre = pat_q >> (PAT_W - k);
        msk = ONES >> (PAT_W - k);
        if ((k <= (32'(base) + 32'd1)) && (((win ^ pre) & msk) == '0)) state_d = SW'(k);
      end
    end
  end

  // Outputs: match follows the next state; count every accepted bit that completes the pattern.
  always_comb begin
    match_d = (state_d == S_FULL);
    inc_c   = in_valid && !cfg_load && (state_d == S_FULL);
  end

  sat_counter #(.W(CNT_W)) u_cnt (
    .clk      (clk),
    .areset_n (areset_n),
    .inc      (inc_c),
    .clr      (cnt_clr),
    .cnt      (match_cnt),
    .sat      (cnt_sat)
  );

  assign match = match_q;

endmodule

// File: doc/seq_pattern_detector.md
# seq_pattern_detector

Parametrised Moore sequence detector for a serial bit stream. The pattern, its width and the overlap mode are configurable, and a saturating match counter is included. It generalises the fixed four-state "101" detector to any pattern of 2..16 bits, gated by a valid qualifier. It sits on serial-input control paths and drives its match flag straight into downstream control logic.

## Interface
- PAT_W, 3: pattern length in bits, legal range 2..16.
- CNT_W, 8: match-counter width, legal range 1..32.
- RST_PAT, 3'b101: pattern register value after reset, PAT_W bits.
- RST_OVL, 1'b1: overlap-mode register value after reset.

- clk  input  1  single clock; all logic on its rising edge.
- areset_n  input  1  asynchronous active-low reset.
- in_valid  input  1  `in` is accepted on a rising edge when in_valid=1.
- in  input  1  serial data bit.
- cfg_load  input  1  loads cfg_pattern and cfg_overlap, and restarts detection.
- cfg_pattern  input  PAT_W  new pattern; MSB is the first bit expected.
- cfg_overlap  input  1  1 = overlapping matches allowed; 0 = non-overlapping.
- cnt_clr  input  1  synchronous clear of match_cnt and cnt_sat.
- match  output  1  Moore output: high while state == PAT_W.
- match_cnt  output  CNT_W  number of matches detected, saturating.
- cnt_sat  output  1  sticky flag: match_cnt has reached all-ones.

## Operation
- State S holds a value in 0..PAT_W: the length of the longest pattern prefix equal to the most recent accepted bits.
- Accepted bit (in_valid=1, cfg_load=0):
  - Next S = the largest k ≤ PAT_W such that the last k bits of (search history ++ in) equal pattern[PAT_W-1 -: k].
  - The history holds at most PAT_W-1 bits before the new bit. Falling back on mismatch must reproduce the KMP failure function exactly.
- Overlap mode: the search history persists across a match. For example, "101" with input 1,0,1,0,1 gives S = 1,2,3,2,3.
- Non-overlap mode: when S == PAT_W, the next accepted bit is evaluated with an empty history. For example, "101" with 1,0,1,0,1 gives S = 1,2,3,0,1.
- in_valid=0: S, history and the counter all hold.
- match is decoded from the S register only and never depends combinationally on `in`.
- Counter:
  - Increments by 1 on every accepted bit whose next S == PAT_W, including a repeated PAT_W.
  - Saturates at 2^CNT_W-1 and sets cnt_sat at that point.
- cfg_load:
  - Loads the pattern and overlap registers, and clears S and history to 0.
  - The `in` bit presented in the same cycle is discarded.
  - The counter is not affected.
- Priority, highest first:
  - areset_n.
  - cfg_load over bit acceptance.
  - cnt_clr over a same-cycle increment (result is 0, cnt_sat=0).
- Reset values: S=0, history=0, pattern=RST_PAT, overlap=RST_OVL, match=0, match_cnt=0, cnt_sat=0.

## Timing
- Latency: match rises on the edge that accepts the final pattern bit and is visible in the following cycle. match_cnt updates on that same edge.
- match stays high until the next accepted bit, cfg_load or reset; idle cycles do not drop it.
- Asserting areset_n low mid-stream forces every output to its reset value immediately, without waiting for a clock edge. Release must be synchronised externally; the block assumes a release clean to clk.
- No combinational path from any input to any output.

## Structure
- Shared package seq_det_pkg holds:
  - the state-width function (clog2 of PAT_W+1);
  - the default-pattern constant 3'b101;
  - the PAT_W/CNT_W legality checks, as elaboration-time assertions.
- One sub-module, sat_counter (parameter W; inputs inc and clr; outputs cnt and sat), holds the saturating counter.
- The prefix-match/fallback logic is combinational in the top module: a loop over k that compares the history against the pattern prefix.

## Test plan
- After reset with defaults, apply in=1,0,1,1,0,1 with in_valid held at 1 → S=1,2,3,1,2,3; match high in cycles 4 and 7; match_cnt=2. This is identical to the legacy "101" detector.
- Set cfg_overlap=0 with pattern 101, apply 1,0,1,0,1 → match once, then S=0,1; match_cnt=1. In overlap mode the same stream gives match_cnt=2.
- PAT_W=4, load 4'b1111 in overlap mode, apply six 1s → match is high from the 4th bit onward and match_cnt=3.
- Use CNT_W=2 and produce 5 matches → match_cnt sticks at 3 and cnt_sat=1. Then pulse cnt_clr in the same cycle as a match → match_cnt=0, cnt_sat=0.
- Toggle in_valid 1,0,0,1 through the 101 stream, with gaps → the result is identical to the ungapped stream and match holds through the idle cycles.
- Two mid-operation events:
  - With S=2, assert cfg_load alongside in=1 → S=0 and the bit is discarded.
  - With match=1, pull areset_n low between clock edges → match, S and match_cnt go to 0 without waiting for a clock edge.
